// File: rtl/alu_issue_queue.sv
// alu_issue_queue: in-order issue buffer in front of a registered, non-stallable 32-bit ALU.
// Latency: command accepted at edge E0 -> rsp_valid after E2 (2 cycles min); 1 cmd/cycle sustained.
// Backpressure: issues only with a guaranteed response slot; cmd_ready drops when the command FIFO is full.
//
// Ports:
//   clk, rst_n                          clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready                 command handshake; cmd_op/a/b/tag are the command payload
//   alu_op/alu_a/alu_b                  combinational view of the command FIFO head (0 when empty)
//   alu_result/alu_carry                registered ALU outputs, valid the cycle after issue
//   rsp_valid/rsp_ready                 response handshake; rsp_result/carry/tag are the oldest result
//   busy                                any command queued, in flight, or response pending

// Generic synchronous FIFO: power-of-2 depth, separate occupancy count.
// Latency: written data is visible at rdata the cycle after the push.
// Backpressure: push is ignored when full, pop ignored when empty; rdata reads 0 when empty.
module aiq_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          empty;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // Full is judged on the current count, so a pop in the same cycle never makes room for a push.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module alu_issue_queue #(
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4,
   parameter int TAG_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [31:0]      cmd_a,
   input  logic [31:0]      cmd_b,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [2:0]       alu_op,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   input  logic [31:0]      alu_result,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic             rsp_carry,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy
);
   localparam int CMD_CW = $clog2(CMD_DEPTH+1);
   localparam int RSP_CW = $clog2(RSP_DEPTH+1);
   localparam int OCC_W  = RSP_CW + 1;

   typedef struct packed {
      logic [2:0]       op;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   typedef struct packed {
      logic [31:0]      result;
      logic             carry;
      logic [TAG_W-1:0] tag;
   } rsp_t;

   cmd_t              cmd_in;
   cmd_t              cmd_head;
   rsp_t              rsp_in;
   rsp_t              rsp_head;
   logic [CMD_CW-1:0] cmd_count;
   logic [RSP_CW-1:0] rsp_count;
   logic [OCC_W-1:0]  rsp_occ;
   logic              ready_en;
   logic              inflight;
   logic [TAG_W-1:0]  tag_q;
   logic              cmd_push;
   logic              issue_fire;
   logic              rsp_pop;

   // Holds cmd_ready low while reset is asserted and until the first clock after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   // ------------------------------------------------------------------ command side
   assign cmd_ready = ready_en & (cmd_count != CMD_CW'(CMD_DEPTH));
   assign cmd_push  = cmd_valid & cmd_ready;
   assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};

   aiq_fifo #(
      .W     ($bits(cmd_t)),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_push),
      .wdata (cmd_in),
      .pop   (issue_fire),
      .rdata (cmd_head),
      .count (cmd_count)
   );

   // The ALU samples the head every cycle; non-issue captures are simply never written back.
   assign alu_op = cmd_head.op;
   assign alu_a  = cmd_head.a;
   assign alu_b  = cmd_head.b;

   // ------------------------------------------------------------------ issue credit
   // A slot is reserved for every stored response and the one in flight. A response
   // leaving this cycle is not counted as free until next cycle, which keeps the
   // credit path free of rsp_ready.
   assign rsp_occ    = {1'b0, rsp_count} + {{RSP_CW{1'b0}}, inflight};
   assign issue_fire = (cmd_count != '0) & (rsp_occ < OCC_W'(RSP_DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= 1'b0;
         tag_q    <= '0;
      end else begin
         inflight <= issue_fire;
         if (issue_fire) begin
            tag_q <= cmd_head.tag;
         end
      end
   end

   // ------------------------------------------------------------------ response side
   assign rsp_in  = '{result: alu_result, carry: alu_carry, tag: tag_q};
   assign rsp_pop = rsp_valid & rsp_ready;

   aiq_fifo #(
      .W     ($bits(rsp_t)),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (inflight),
      .wdata (rsp_in),
      .pop   (rsp_pop),
      .rdata (rsp_head),
      .count (rsp_count)
   );

   assign rsp_valid  = (rsp_count != '0);
   assign rsp_result = rsp_head.result;
   assign rsp_carry  = rsp_head.carry;
   assign rsp_tag    = rsp_head.tag;

   assign busy = (cmd_count != '0) | inflight | (rsp_count != '0);

   // The ALU cannot stall, so a capture into a full response FIFO would lose a result.
   a_rsp_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      inflight |-> (rsp_count != RSP_CW'(RSP_DEPTH)));
endmodule
